// File: rtl/axi4_globals_pkg.sv
// axi4_globals_pkg: shared AXI4 slave types and depths (outstanding FIFO depth, BRESP codes, AW entry, write FSM states)
package axi4_globals_pkg;
  localparam int OUTSTANDING_FIFO_DEPTH = 16;
  typedef enum logic [1:0] {
    WRITE_OKAY   = 2'b00,
    WRITE_EXOKAY = 2'b01,
    WRITE_SLVERR = 2'b10,
    WRITE_DECERR = 2'b11
  } bresp_e;
  typedef struct packed {
    logic [3:0] awid;
    logic [7:0] awlen;
  } axi4_aw_entry_s;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} axi4_wresp_state_e;
endpackage

// File: rtl/axi4_slave_write_resp_gen_if.sv
// axi4_slave_write_resp_gen_if: AW/W/B slave-side signal bundle (master drives awid/awlen/awvalid/wlast/wvalid/bready; slave drives awready/wready/bid/bresp/bvalid/outstanding_count)
interface axi4_slave_write_resp_gen_if #(parameter int ID_WIDTH = 4);
  logic [ID_WIDTH-1:0] awid;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [4:0]          outstanding_count;
  modport master (output awid, awlen, awvalid, wlast, wvalid, bready,
                  input  awready, wready, bid, bresp, bvalid, outstanding_count);
  modport slave  (input  awid, awlen, awvalid, wlast, wvalid, bready,
                  output awready, wready, bid, bresp, bvalid, outstanding_count);
endinterface

// File: rtl/axi4_sync_fifo.sv
// axi4_sync_fifo: synchronous FIFO of T (ports clk, rst async active-high, push/din, pop/dout, full, empty, count); push ignored when full, pop ignored when empty
module axi4_sync_fifo #(
  parameter type T = logic [11:0],
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  T              mem_q [DEPTH];
  assign full    = cnt_q == CW'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_comb begin
    wr_d  = do_push ? ((wr_q == LAST) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = do_pop ? ((rd_q == LAST) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/axi4_slave_write_resp_gen.sv
// axi4_slave_write_resp_gen: AW FIFO + W/B engine, one B per burst (ports aclk, areset async active-high, s = slave modport); AXI4_BRESP_LEN_CHECK_EN adds beat-count SLVERR
module axi4_slave_write_resp_gen
  import axi4_globals_pkg::*;
#(
  parameter int DEPTH    = OUTSTANDING_FIFO_DEPTH,
  parameter int ID_WIDTH = 4
) (
  input logic aclk,
  input logic areset,
  axi4_slave_write_resp_gen_if.slave s
);
  localparam int CW = $clog2(DEPTH + 1);
  axi4_wresp_state_e   state_q, state_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  bresp_e              bresp_q, bresp_d;
  axi4_aw_entry_s      entry, head;
  logic                push, pop, full, empty;
  logic [CW-1:0]       count;
`ifdef AXI4_BRESP_LEN_CHECK_EN
  logic [7:0]          beat_q, beat_d;
`else
  logic                unused_len;
  assign unused_len = ^head.awlen;
`endif
  assign entry = '{awid: s.awid, awlen: s.awlen};
  assign push  = s.awvalid && !full;
  assign pop   = bvalid_q && s.bready;
  axi4_sync_fifo #(.T(axi4_aw_entry_s), .DEPTH(DEPTH)) u_fifo (
    .clk(aclk), .rst(areset), .push(push), .din(entry), .pop(pop),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign s.awready           = !full;
  assign s.wready            = state_q == W_DATA;
  assign s.bvalid            = bvalid_q;
  assign s.bid               = bid_q;
  assign s.bresp             = bresp_q;
  assign s.outstanding_count = count;
  always_comb begin
    state_d  = state_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
`ifdef AXI4_BRESP_LEN_CHECK_EN
    beat_d   = beat_q;
`endif
    case (state_q)
      W_IDLE: state_d = empty ? W_IDLE : W_DATA;
      W_DATA: begin
`ifdef AXI4_BRESP_LEN_CHECK_EN
        if (s.wvalid) beat_d = (beat_q == 8'hff) ? beat_q : beat_q + 8'd1;
`endif
        if (s.wvalid && s.wlast) begin
          state_d  = W_RESP;
          bvalid_d = 1'b1;
          bid_d    = head.awid;
`ifdef AXI4_BRESP_LEN_CHECK_EN
          // beat_q is the 0-based index of this wlast beat
          bresp_d  = (beat_q != head.awlen) ? WRITE_SLVERR : WRITE_OKAY;
`else
          bresp_d  = WRITE_OKAY;
`endif
        end
      end
      W_RESP: begin
        if (s.bready) begin
          bvalid_d = 1'b0;
          // entries left after this pop, counting a same-cycle push
          state_d  = (count > CW'(1) || push) ? W_DATA : W_IDLE;
`ifdef AXI4_BRESP_LEN_CHECK_EN
          beat_d   = 8'd0;
`endif
        end
      end
      default: state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= W_IDLE;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= WRITE_OKAY;
`ifdef AXI4_BRESP_LEN_CHECK_EN
      beat_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
`ifdef AXI4_BRESP_LEN_CHECK_EN
      beat_q   <= beat_d;
`endif
    end
  end
endmodule
